// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters with sync, active-video and per-frame animate decode
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       h_sync,
    output logic       v_sync,
    output logic       active,
    output logic       animate,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    // Decode bounds are 11 bits so an end-of-sync edge at exactly 1024 stays representable.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] x_ext;
    logic [10:0] y_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            if (x == H_LAST) begin
                x <= '0;
                y <= (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};

    // Outputs decode the live counters so they line up with x/y in the same cycle.
    assign h_sync  = (x_ext >= HS_START && x_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign v_sync  = (y_ext >= VS_START && y_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign active  = (x_ext < H_ACT) && (y_ext < V_ACT);
    assign animate = (y_ext == V_ACT) && (x == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a shrunken 25x17 raster
module tb_vga_timing_gen;

    // Small raster: H 16+2+4+3 = 25, V 10+2+2+3 = 17, frame = 425 cycles.
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int FRAME = 425;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b1;
    logic       h_sync, v_sync, active, animate;
    logic [9:0] x, y;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_sync(h_sync), .v_sync(v_sync), .active(active), .animate(animate),
        .x(x), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } chk_t;

    logic [23:0] exp_q[$];
    chk_t        chk_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cnt_act = 0, cnt_vs = 0, cnt_hs = 0, cnt_anim = 0;
    int anim_prev = 0, anim_last = 0;
    int mx = 0, my = 0;

    function automatic logic [23:0] model_out();
        logic hs_l, vs_l, act_l, anim_l;
        hs_l   = !((mx >= 18) && (mx < 22));
        vs_l   = !((my >= 12) && (my < 14));
        act_l  = (mx < 16) && (my < 10);
        anim_l = (my == 10) && (mx == 0);
        return {10'(mx), 10'(my), hs_l, vs_l, act_l, anim_l};
    endfunction

    // Sole writer of the comparison counters.
    always @(negedge clk) begin
        logic [23:0] e;
        logic [23:0] g;
        chk_t c;
        cyc++;
        if (active === 1'b1)  cnt_act++;
        if (v_sync === 1'b0)  cnt_vs++;
        if (h_sync === 1'b0)  cnt_hs++;
        if (animate === 1'b1) begin
            cnt_anim++;
            anim_prev = anim_last;
            anim_last = cyc;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {x, y, h_sync, v_sync, active, animate};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL scoreboard cyc=%0d got x=%0d y=%0d hs=%b vs=%b act=%b anim=%b required x=%0d y=%0d hs=%b vs=%b act=%b anim=%b",
                         cyc, g[23:14], g[13:4], g[3], g[2], g[1], g[0],
                         e[23:14], e[13:4], e[3], e[2], e[1], e[0]);
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.got != c.exp) begin
                n_bad++;
                $display("FAIL %s got %0d required %0d", c.name, c.got, c.exp);
            end
        end
    end

    task automatic dchk(input string name, input int got, input int exp);
        chk_q.push_back('{name, got, exp});
    endtask

    task automatic step(input logic r, input logic e);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        if (r) begin
            mx = 0;
            my = 0;
        end else if (e) begin
            if (mx == 24) begin
                mx = 0;
                my = (my == 16) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(mx == tx && my == ty) && n < 1000) begin
            step(1'b0, 1'b1);
            n++;
        end
        if (n >= 1000) dchk("run_to_timeout", 1, 0);
    endtask

    task automatic check_frame(input string tag);
        int a0, v0, h0, n0;
        a0 = cnt_act; v0 = cnt_vs; h0 = cnt_hs; n0 = cnt_anim;
        repeat (FRAME) step(1'b0, 1'b1);
        dchk({tag, "_x"}, int'(x), 0);
        dchk({tag, "_y"}, int'(y), 0);
        dchk({tag, "_active_cycles"}, cnt_act - a0, 16 * 10);
        dchk({tag, "_vsync_low_cycles"}, cnt_vs - v0, 2 * 25);
        dchk({tag, "_hsync_low_cycles"}, cnt_hs - h0, 4 * 17);
        dchk({tag, "_animate_pulses"}, cnt_anim - n0, 1);
    endtask

    initial begin
        int n0;
        @(negedge clk);
        #1;

        // Reset held three cycles, then free-run five.
        repeat (3) step(1'b1, 1'b1);
        dchk("rst_x", int'(x), 0);
        dchk("rst_y", int'(y), 0);
        dchk("rst_hsync", int'(h_sync), 1);
        dchk("rst_vsync", int'(v_sync), 1);
        dchk("rst_active", int'(active), 1);
        dchk("rst_animate", int'(animate), 0);
        repeat (5) step(1'b0, 1'b1);
        dchk("post_rst_x", int'(x), 5);
        dchk("post_rst_y", int'(y), 0);

        // Line edges: active drop at x=16, wrap 24->0 bumps y.
        run_to(15, 0);
        dchk("last_active_pixel", int'(active), 1);
        step(1'b0, 1'b1);
        dchk("first_blank_pixel", int'(active), 0);
        run_to(24, 0);
        step(1'b0, 1'b1);
        dchk("wrap_x", int'(x), 0);
        dchk("wrap_y", int'(y), 1);

        // One frame from reset, then two frames for animate spacing.
        step(1'b1, 1'b1);
        check_frame("frame0");
        n0 = cnt_anim;
        repeat (2 * FRAME) step(1'b0, 1'b1);
        dchk("anim_two_frames", cnt_anim - n0, 2);
        dchk("anim_spacing", anim_last - anim_prev, FRAME);

        // Stall mid-line: everything frozen, resumes at next pixel.
        run_to(10, 3);
        repeat (10) step(1'b0, 1'b0);
        dchk("stall_x", int'(x), 10);
        dchk("stall_y", int'(y), 3);
        step(1'b0, 1'b1);
        dchk("resume_x", int'(x), 11);

        // Stall on the animate pixel keeps the strobe high.
        run_to(0, 10);
        n0 = cnt_anim;
        repeat (6) step(1'b0, 1'b0);
        dchk("anim_held_cycles", cnt_anim - n0, 6);
        step(1'b0, 1'b1);
        dchk("anim_after_stall", int'(animate), 0);

        // Mid-frame reset restarts at (0,0) and the next frame is normal.
        run_to(20, 8);
        step(1'b1, 1'b1);
        dchk("midrst_x", int'(x), 0);
        dchk("midrst_y", int'(y), 0);
        dchk("midrst_active", int'(active), 1);
        dchk("midrst_hsync", int'(h_sync), 1);
        dchk("midrst_vsync", int'(v_sync), 1);
        check_frame("frame1");

        repeat (2) @(negedge clk);
        dchk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
